// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: tracks jump/left/right key state with last-pressed-wins
// direction arbitration and a prefix-sequence timeout. Define PS2_WASD_EN for W/A/D aliases.
module ps2_key_decoder #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter logic [7:0]  SC_SPACE   = 8'h29,
    parameter logic [7:0]  SC_LEFT    = 8'h6B,
    parameter logic [7:0]  SC_RIGHT   = 8'h74
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       key_space,
    output logic       key_left,
    output logic       key_right,
    output logic       seq_error
);

    localparam int unsigned TO_MAX = CLK_FREQ / 1_000_000 * TIMEOUT_US - 1;
    localparam int unsigned TO_W   = (TO_MAX > 0) ? $clog2(TO_MAX + 1) : 1;
    localparam logic [TO_W-1:0] TO_MAX_C = TO_W'(TO_MAX);

    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BRK   = 8'hF0;
    localparam logic [7:0] B_PAUSE = 8'hE1;
`ifdef PS2_WASD_EN
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;
    localparam logic [7:0] SC_W = 8'h1D;
`endif

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXT     = 3'd1,
        S_BRK     = 3'd2,
        S_EXT_BRK = 3'd3,
        S_PAUSE   = 3'd4
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]      skip_q, skip_d;
    dir_t            dir_q, dir_d;
    logic            space_held_q, space_held_d;
    logic            left_held_q, left_held_d;
    logic            right_held_q, right_held_d;
`ifdef PS2_WASD_EN
    logic            a_held_q, a_held_d;
    logic            d_held_q, d_held_d;
    logic            w_held_q, w_held_d;
`endif
    logic            key_space_q, key_space_d;
    logic            key_left_q, key_left_d;
    logic            key_right_q, key_right_d;
    logic            seq_error_q, seq_error_d;

    logic            ev_make_s, ev_break_s, ev_ext_s;
    logic            hit_left_s, hit_right_s;
    logic            left_any_s, right_any_s;

    // Sequence FSM and prefix timeout; a byte always takes priority over the timeout
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = '0;
        skip_d      = skip_q;
        seq_error_d = 1'b0;
        ev_make_s   = 1'b0;
        ev_break_s  = 1'b0;
        ev_ext_s    = 1'b0;
        if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == B_EXT) begin
                        state_d = S_EXT;
                    end else if (rx_data == B_BRK) begin
                        state_d = S_BRK;
                    end else if (rx_data == B_PAUSE) begin
                        state_d = S_PAUSE;
                        skip_d  = 3'd7;
                    end else begin
                        ev_make_s = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == B_BRK) begin
                        state_d = S_EXT_BRK;
                    end else begin
                        ev_make_s = 1'b1;
                        ev_ext_s  = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
                S_BRK: begin
                    ev_break_s = 1'b1;
                    state_d    = S_IDLE;
                end
                S_EXT_BRK: begin
                    ev_break_s = 1'b1;
                    ev_ext_s   = 1'b1;
                    state_d    = S_IDLE;
                end
                S_PAUSE: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q <= 3'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_PAUSE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (to_cnt_q == TO_MAX_C) begin
                state_d     = S_IDLE;
                seq_error_d = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end else begin
            to_cnt_d = '0;
        end
    end

    // Held flags, direction arbitration and next output values
    always_comb begin
        space_held_d = space_held_q;
        left_held_d  = left_held_q;
        right_held_d = right_held_q;
`ifdef PS2_WASD_EN
        a_held_d     = a_held_q;
        d_held_d     = d_held_q;
        w_held_d     = w_held_q;
`endif
        hit_left_s   = ev_ext_s && (rx_data == SC_LEFT);
        hit_right_s  = ev_ext_s && (rx_data == SC_RIGHT);
        if (ev_make_s || ev_break_s) begin
            if (!ev_ext_s && rx_data == SC_SPACE) space_held_d = ev_make_s;
            else                                  space_held_d = space_held_d;
            if (hit_left_s)  left_held_d  = ev_make_s;
            else             left_held_d  = left_held_d;
            if (hit_right_s) right_held_d = ev_make_s;
            else             right_held_d = right_held_d;
`ifdef PS2_WASD_EN
            if (!ev_ext_s && rx_data == SC_A) begin
                a_held_d   = ev_make_s;
                hit_left_s = 1'b1;
            end else begin
                a_held_d   = a_held_d;
            end
            if (!ev_ext_s && rx_data == SC_D) begin
                d_held_d    = ev_make_s;
                hit_right_s = 1'b1;
            end else begin
                d_held_d    = d_held_d;
            end
            if (!ev_ext_s && rx_data == SC_W) w_held_d = ev_make_s;
            else                              w_held_d = w_held_d;
`endif
        end else begin
            space_held_d = space_held_q;
        end

`ifdef PS2_WASD_EN
        left_any_s  = left_held_d | a_held_d;
        right_any_s = right_held_d | d_held_d;
        key_space_d = space_held_d | w_held_d;
`else
        left_any_s  = left_held_d;
        right_any_s = right_held_d;
        key_space_d = space_held_d;
`endif

        // Releasing one direction hands control to the other only if it is fully released
        dir_d = dir_q;
        if (ev_make_s && hit_left_s) begin
            dir_d = DIR_LEFT;
        end else if (ev_make_s && hit_right_s) begin
            dir_d = DIR_RIGHT;
        end else if (ev_break_s && hit_left_s && !left_any_s && right_any_s) begin
            dir_d = DIR_RIGHT;
        end else if (ev_break_s && hit_right_s && !right_any_s && left_any_s) begin
            dir_d = DIR_LEFT;
        end else begin
            dir_d = dir_q;
        end

        key_left_d  = left_any_s  & (~right_any_s | (dir_d == DIR_LEFT));
        key_right_d = right_any_s & (~left_any_s  | (dir_d == DIR_RIGHT));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            to_cnt_q     <= '0;
            skip_q       <= 3'd0;
            dir_q        <= DIR_LEFT;
            space_held_q <= 1'b0;
            left_held_q  <= 1'b0;
            right_held_q <= 1'b0;
`ifdef PS2_WASD_EN
            a_held_q     <= 1'b0;
            d_held_q     <= 1'b0;
            w_held_q     <= 1'b0;
`endif
            key_space_q  <= 1'b0;
            key_left_q   <= 1'b0;
            key_right_q  <= 1'b0;
            seq_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            to_cnt_q     <= to_cnt_d;
            skip_q       <= skip_d;
            dir_q        <= dir_d;
            space_held_q <= space_held_d;
            left_held_q  <= left_held_d;
            right_held_q <= right_held_d;
`ifdef PS2_WASD_EN
            a_held_q     <= a_held_d;
            d_held_q     <= d_held_d;
            w_held_q     <= w_held_d;
`endif
            key_space_q  <= key_space_d;
            key_left_q   <= key_left_d;
            key_right_q  <= key_right_d;
            seq_error_q  <= seq_error_d;
        end
    end

    assign key_space = key_space_q;
    assign key_left  = key_left_q;
    assign key_right = key_right_q;
    assign seq_error = seq_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder; timeout shortened to 20 cycles (TO_MAX = 19).
module tb_ps2_key_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_space, key_left, key_right, seq_error;
    logic [3:0] outs_s;
    int         n_tests;
    int         n_fail;
    int         err_pulses;

    ps2_key_decoder #(
        .CLK_FREQ  (1_000_000),
        .TIMEOUT_US(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .key_space(key_space),
        .key_left (key_left),
        .key_right(key_right),
        .seq_error(seq_error)
    );

    assign outs_s = {key_space, key_left, key_right, seq_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count seq_error cycles to prove single-cycle pulses
    always @(posedge clk) begin
        if (seq_error) err_pulses <= err_pulses + 1;
    end

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Output vector order: {space, left, right, seq_error}
    initial begin
        n_tests    = 0;
        n_fail     = 0;
        err_pulses = 0;
        rst        = 1'b1;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset", {4'b0, outs_s}, 8'b0000_0000);

        // Space make/break
        send_byte(8'h29);                 check_eq("space_make", {4'b0, outs_s}, 8'b0000_1000);
        send_byte(8'hF0);                 check_eq("space_f0", {4'b0, outs_s}, 8'b0000_1000);
        send_byte(8'h29);                 check_eq("space_break", {4'b0, outs_s}, 8'b0000_0000);
        send_byte(8'hE0); send_byte(8'h29); check_eq("ext_29_ignored", {4'b0, outs_s}, 8'b0000_0000);

        // Right arrow and keypad 6/4
        send_byte(8'hE0); send_byte(8'h74); check_eq("right_make", {4'b0, outs_s}, 8'b0000_0010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check_eq("right_break", {4'b0, outs_s}, 8'b0000_0000);
        send_byte(8'h74);                 check_eq("kp6_ignored", {4'b0, outs_s}, 8'b0000_0000);
        send_byte(8'h6B);                 check_eq("kp4_ignored", {4'b0, outs_s}, 8'b0000_0000);

        // Left/right conflict, last pressed wins
        send_byte(8'hE0); send_byte(8'h6B); check_eq("left_make", {4'b0, outs_s}, 8'b0000_0100);
        send_byte(8'hE0); send_byte(8'h74); check_eq("conflict_right", {4'b0, outs_s}, 8'b0000_0010);
        send_byte(8'hE0); send_byte(8'h6B); check_eq("typematic_left", {4'b0, outs_s}, 8'b0000_0100);
        send_byte(8'hE0); send_byte(8'h74); check_eq("typematic_right", {4'b0, outs_s}, 8'b0000_0010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check_eq("left_remains", {4'b0, outs_s}, 8'b0000_0100);
        send_byte(8'hE0); send_byte(8'h74); check_eq("right_again", {4'b0, outs_s}, 8'b0000_0010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        check_eq("right_remains", {4'b0, outs_s}, 8'b0000_0010);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check_eq("all_released", {4'b0, outs_s}, 8'b0000_0000);

        // Alias code: unknown in the default build
        send_byte(8'h1C);
`ifdef PS2_WASD_EN
        check_eq("code_1c", {4'b0, outs_s}, 8'b0000_0100);
        send_byte(8'hF0); send_byte(8'h1C);
`else
        check_eq("code_1c", {4'b0, outs_s}, 8'b0000_0000);
`endif
        check_eq("code_1c_clear", {4'b0, outs_s}, 8'b0000_0000);

        // Timeout after E0: fires on the 20th idle cycle
        err_pulses = 0;
        send_byte(8'hE0);
        repeat (19) @(negedge clk);
        check_eq("to_not_yet", {4'b0, outs_s}, 8'b0000_0000);
        @(negedge clk);
        check_eq("to_fire", {4'b0, outs_s}, 8'b0000_0001);
        @(negedge clk);
        check_eq("to_pulse_end", {4'b0, outs_s}, 8'b0000_0000);
        check_eq("to_pulse_count", 8'(err_pulses), 8'd1);
        send_byte(8'h29);                 check_eq("to_then_space", {4'b0, outs_s}, 8'b0000_1000);

        // Timeout in BRK keeps held flags
        send_byte(8'hF0);
        repeat (20) @(negedge clk);
        check_eq("to_brk_keeps", {4'b0, outs_s}, 8'b0000_1001);
        send_byte(8'hF0); send_byte(8'h29);
        check_eq("space_release", {4'b0, outs_s}, 8'b0000_0000);

        // Byte arriving on the timeout cycle wins
        err_pulses = 0;
        send_byte(8'hE0);
        repeat (18) @(negedge clk);
        send_byte(8'h74);
        check_eq("to_byte_wins", {4'b0, outs_s}, 8'b0000_0010);
        @(negedge clk);
        check_eq("to_byte_no_err", 8'(err_pulses), 8'd0);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        check_eq("to_byte_clean", {4'b0, outs_s}, 8'b0000_0000);

        // Pause sequence swallowed
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h29);
        check_eq("pause_no_effect", {4'b0, outs_s}, 8'b0000_0000);
        send_byte(8'h29);                 check_eq("pause_then_space", {4'b0, outs_s}, 8'b0000_1000);
        send_byte(8'hF0); send_byte(8'h29);
        check_eq("pause_space_rel", {4'b0, outs_s}, 8'b0000_0000);

        // Reset mid-sequence
        send_byte(8'hE0); send_byte(8'h6B); check_eq("rst_pre_left", {4'b0, outs_s}, 8'b0000_0100);
        send_byte(8'hE0); send_byte(8'hF0);
        pulse_reset();
        check_eq("rst_mid", {4'b0, outs_s}, 8'b0000_0000);
        send_byte(8'h6B);                 check_eq("rst_then_6b", {4'b0, outs_s}, 8'b0000_0000);
        send_byte(8'hE0); send_byte(8'h74); check_eq("rst_then_right", {4'b0, outs_s}, 8'b0000_0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
